uart_io_port: RTL
=================

// Module: uart_io_port
// PURPOSE
//  Responder side of the CPU byte-IO handshake: sources io_in_* bytes, sinks io_out_* bytes.
//  Bridges them to a UART line (8 data bits, LSB first, 1 stop bit, idle high).
//  RX and TX FIFOs decouple the CPU stall loop from line timing.
//  Sits between the core's IO ports and the board's serial pins; io_err feeds the core's io_err input.
// PARAMETERS
//  CLKS_PER_BIT   868  clk cycles per UART bit (100 MHz / 115200); legal range 4..65535
//  RX_DEPTH_LOG2  4    RX FIFO depth = 2**RX_DEPTH_LOG2 (16)
//  TX_DEPTH_LOG2  4    TX FIFO depth = 2**TX_DEPTH_LOG2 (16)
// PORTS
//  clk          in   1  clock
//  rstn         in   1  reset, synchronous, active-low
//  io_in_data   out  8  RX FIFO head byte to CPU
//  io_in_vld    out  1  RX FIFO not empty
//  io_in_rdy    in   1  CPU accepts head byte
//  io_out_data  in   8  byte from CPU
//  io_out_vld   in   1  CPU offers a byte
//  io_out_rdy   out  1  TX FIFO not full
//  io_err       out  5  sticky error flags (see BEHAVIOUR)
//  err_clr      in   1  one-cycle pulse clears io_err
//  uart_rx      in   1  serial in (asynchronous)
//  uart_tx      out  1  serial out
// BEHAVIOUR
//  Reset: FIFOs emptied, io_in_vld=0, io_out_rdy=1, io_err=0, uart_tx=1, both FSMs IDLE; io_in_data=0.
//  Mid-frame reset: frame is abandoned; uart_tx=1 from the first reset cycle.
//  Handshake: a transfer occurs on a posedge where vld&&rdy; data is held stable while vld=1.
//  io_in_data is first-word-fall-through; the next byte appears the cycle after the pop.
//  io_out_rdy = !tx_full; it is computed from the registered count and ignores a same-cycle pop.
//  RX push when full: accepted if a CPU pop happens in the same cycle.
//    Otherwise the byte is dropped and io_err[0] (overrun) is set.
//  RX FSM IDLE->START->DATA->STOP->IDLE:
//    uart_rx passes through a 2-FF synchronizer; a falling edge in IDLE enters START.
//    At CLKS_PER_BIT/2 the line is resampled.
//      Still low: enter DATA.
//      High: set io_err[3] (false start) and return to IDLE.
//    DATA samples 8 bits at mid-bit intervals of CLKS_PER_BIT, LSB first.
//    STOP samples at mid-bit.
//      Stop=1: push byte; IDLE.
//      Stop=0: set io_err[1] (framing), discard byte, then wait for line high before IDLE.
//    Push occurs 1 cycle after the stop-bit mid sample.
//  TX FSM IDLE->START->DATA->STOP->IDLE:
//    IDLE with FIFO non-empty pops the head into a shift register.
//    uart_tx drives the start bit from the next cycle.
//    Each bit lasts exactly CLKS_PER_BIT cycles.
//    Frame = 10*CLKS_PER_BIT cycles (11 with parity).
//    Back-to-back: the next start bit begins on the cycle after the stop bit ends (no idle gap).
//  Empty-FIFO latency: byte accepted at cycle t, start bit on uart_tx at t+2.
//  io_err[4] reserved, always 0.
//  Error-bit set and err_clr in the same cycle: set wins.
//  Counters: bit-timer width $clog2(CLKS_PER_BIT); FIFO pointers wrap modulo depth; count width LOG2+1.
// CONFIGURATION
//  UART_PARITY_EN defined:
//    TX inserts an even-parity bit after D7; RX checks it.
//    On mismatch: set io_err[2] and discard the byte (stop bit still checked).
//    Framing error takes precedence: only io_err[1] is set.
//  UART_PARITY_EN undefined: no parity bit; io_err[2] tied 0.
// TESTING (CLKS_PER_BIT=4, parity off unless stated)
//  1. rstn=0 for 2 clk -> uart_tx=1, io_in_vld=0, io_out_rdy=1, io_err=5'b0.
//  2. Write 0x41 -> uart_tx low 4 clk, then bits 1,0,0,0,0,0,1,0 (4 clk each), high 4 clk.
//     Start bit at t+2; frame length 40 clk.
//  3. Drive frame 0xA5 on uart_rx -> io_in_vld=1, io_in_data=0xA5; pulse io_in_rdy -> io_in_vld=0.
//  4. 18 writes with io_out_vld held high -> 17 accepted (1 in shifter, 16 queued), then io_out_rdy=0.
//     io_out_rdy=1 again after the first frame ends; all 17 bytes appear in order.
//  5. 17 RX frames with io_in_rdy=0 -> 16 bytes stored, io_err[0]=1, 17th byte lost; err_clr -> io_err=0.
//  6. RX frame 0x3C with stop bit 0 -> no push, io_err[1]=1.
//     A 1-clk low glitch on idle uart_rx -> io_err[3]=1, no push.
//     With UART_PARITY_EN: TX 0x07 emits parity 1; RX 0x07 with parity 0 -> io_err[2]=1, no push.

Source files
------------

// File: rtl/uart_io_port.sv
// CPU byte-IO responder bridged to an 8N1 UART line through RX and TX FIFOs.
// Optional even parity on both directions when UART_PARITY_EN is defined.
module uart_io_port #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rstn,
  output logic [7:0] io_in_data,
  output logic       io_in_vld,
  input  logic       io_in_rdy,
  input  logic [7:0] io_out_data,
  input  logic       io_out_vld,
  output logic       io_out_rdy,
  output logic [4:0] io_err,
  input  logic       err_clr,
  input  logic       uart_rx,
  output logic       uart_tx
);
  localparam int TW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int RCW = RX_DEPTH_LOG2 + 1;
  localparam int TCW = TX_DEPTH_LOG2 + 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT} state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]               tx_mem [1 << TX_DEPTH_LOG2];
  logic [TX_DEPTH_LOG2-1:0] tx_wr, tx_rd;
  logic [TCW-1:0]           tx_cnt;
  logic                     tx_push, tx_load, tx_empty;
  logic [7:0]               tx_head;

  assign io_out_rdy = !tx_cnt[TCW-1];
  assign tx_push    = io_out_vld && io_out_rdy;
  assign tx_empty   = (tx_cnt == '0);
  assign tx_head    = tx_mem[tx_rd];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_load) tx_rd <= tx_rd + 1'b1;
      tx_cnt <= tx_cnt + TCW'(tx_push) - TCW'(tx_load);
    end
  end

  // NOTE: FIFO storage carries no reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= io_out_data;
  end

  // ---------------- TX FSM ----------------
  state_t         tx_state, tx_state_n;
  logic [TW-1:0]  tx_tmr, tx_tmr_n;
  logic [2:0]     tx_bit, tx_bit_n;
  logic [7:0]     tx_sh, tx_sh_n;
  logic           tx_d, tx_q, tx_last;

  assign tx_last = (tx_tmr == T_LAST);
  assign uart_tx = tx_q;

`ifdef UART_PARITY_EN
  logic tx_par;
  always_ff @(posedge clk) begin
    if (!rstn)        tx_par <= 1'b0;
    else if (tx_load) tx_par <= ^tx_head;
  end
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    tx_state_n = tx_state;
    tx_tmr_n   = tx_tmr;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_d       = 1'b1;
    tx_load    = 1'b0;
    case (tx_state)
      S_IDLE:  tx_load = !tx_empty;
      S_START: begin
        tx_d = 1'b0;
        if (tx_last) tx_state_n = S_DATA;
      end
      S_DATA: begin
        tx_d = tx_sh[0];
        if (tx_last) begin
          tx_sh_n  = tx_sh >> 1;
          tx_bit_n = tx_bit + 1'b1;
`ifdef UART_PARITY_EN
          if (tx_bit == 3'd7) tx_state_n = S_PAR;
`else
          if (tx_bit == 3'd7) tx_state_n = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: begin
        tx_d = tx_par;
        if (tx_last) tx_state_n = S_STOP;
      end
`endif
      S_STOP: begin
        if (tx_last) begin
          // Back-to-back frames: reload straight from the stop bit, no idle gap.
          tx_load = !tx_empty;
          if (tx_empty) tx_state_n = S_IDLE;
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
    if (tx_state != S_IDLE) tx_tmr_n = tx_last ? '0 : tx_tmr + 1'b1;
    if (tx_load) begin
      tx_state_n = S_START;
      tx_tmr_n   = '0;
      tx_bit_n   = '0;
      tx_sh_n    = tx_head;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state <= S_IDLE;
      tx_tmr   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_tmr   <= tx_tmr_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      tx_q     <= tx_d;
    end
  end

  // ---------------- RX FSM ----------------
  logic           rx_s1, rx_s2, rx_s3;
  state_t         rx_state, rx_state_n;
  logic [TW-1:0]  rx_tmr, rx_tmr_n;
  logic [2:0]     rx_bit, rx_bit_n;
  logic [7:0]     rx_sh, rx_sh_n;
  logic           rx_push, rx_push_n, rx_last;
  logic           set_fs, set_frm, set_par;

  assign rx_last = (rx_tmr == T_LAST);

`ifdef UART_PARITY_EN
  logic rx_par_bad;
  always_ff @(posedge clk) begin
    if (!rstn)                              rx_par_bad <= 1'b0;
    else if (rx_state == S_PAR && rx_last) rx_par_bad <= rx_s2 ^ (^rx_sh);
  end
`endif

  always_comb begin
    rx_state_n = rx_state;
    rx_tmr_n   = rx_last ? '0 : rx_tmr + 1'b1;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_push_n  = 1'b0;
    set_fs     = 1'b0;
    set_frm    = 1'b0;
    set_par    = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_tmr_n = '0;
        if (rx_s3 && !rx_s2) rx_state_n = S_START;
      end
      S_START: begin
        if (rx_tmr == T_HALF) begin
          rx_tmr_n = '0;
          rx_bit_n = '0;
          if (!rx_s2) rx_state_n = S_DATA;
          else begin
            set_fs     = 1'b1;
            rx_state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (rx_last) begin
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          rx_bit_n = rx_bit + 1'b1;
`ifdef UART_PARITY_EN
          if (rx_bit == 3'd7) rx_state_n = S_PAR;
`else
          if (rx_bit == 3'd7) rx_state_n = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: if (rx_last) rx_state_n = S_STOP;
`endif
      S_STOP: begin
        if (rx_last) begin
          if (rx_s2) begin
            rx_state_n = S_IDLE;
`ifdef UART_PARITY_EN
            if (rx_par_bad) set_par = 1'b1;
            else            rx_push_n = 1'b1;
`else
            rx_push_n = 1'b1;
`endif
          end else begin
            // Framing error outranks parity; hold off until the line idles.
            set_frm    = 1'b1;
            rx_state_n = S_WAIT;
          end
        end
      end
      S_WAIT: if (rx_s2) rx_state_n = S_IDLE;
      default: rx_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= S_IDLE;
      rx_tmr   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_push  <= 1'b0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_state_n;
      rx_tmr   <= rx_tmr_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      rx_push  <= rx_push_n;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]               rx_mem [1 << RX_DEPTH_LOG2];
  logic [RX_DEPTH_LOG2-1:0] rx_wr, rx_rd;
  logic [RCW-1:0]           rx_cnt;
  logic                     rx_pop, rx_full, rx_wen, set_ovr;

  assign io_in_vld  = (rx_cnt != '0);
  assign io_in_data = io_in_vld ? rx_mem[rx_rd] : 8'h00;
  assign rx_pop     = io_in_vld && io_in_rdy;
  assign rx_full    = rx_cnt[RCW-1];
  assign rx_wen     = rx_push && (!rx_full || rx_pop);
  assign set_ovr    = rx_push && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_wen) rx_wr <= rx_wr + 1'b1;
      if (rx_pop) rx_rd <= rx_rd + 1'b1;
      rx_cnt <= rx_cnt + RCW'(rx_wen) - RCW'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wen) rx_mem[rx_wr] <= rx_sh;
  end

  // Sticky errors: a same-cycle set survives err_clr.
  always_ff @(posedge clk) begin
    if (!rstn) io_err <= '0;
    else       io_err <= (err_clr ? 5'b0 : io_err) | {1'b0, set_fs, set_par, set_frm, set_ovr};
  end
endmodule
